wash_cycle_sequencer: RTL
=========================

// Module: wash_cycle_sequencer
// PURPOSE
//  Program sequencer for the washing-machine datapath: fill, wash, drain, N rinses, spin.
//  Owns the door lock, fill valve, drain valve and motor.
//  Times each phase with an internal down-counter.
//  Watchdogs the fill/drain sensors and parks the machine safely on fault, abort or door-open.
//  Sits between the front-panel inputs (start, abort) and the valve/motor/lock drivers.
// PARAMETERS
//  CNT_W          8   width of phase timer and watchdog counters
//  WASH_TICKS     20  clk cycles motor runs in WASH (soap wash), >=1
//  RINSE_TICKS    10  clk cycles motor runs in each RINSE (water wash), >=1
//  SPIN_TICKS     15  clk cycles motor runs in SPIN with drain open, >=1
//  RINSES         2   rinse repeats after wash; 0 = skip rinse, go DRAIN->SPIN
//  FILL_LIMIT     50  max cycles in a fill state before fault
//  DRAIN_LIMIT    50  max cycles in a drain state before fault
// PORTS
//  clk              in   1  single clock, rising edge
//  reset            in   1  asynchronous, active-high
//  start            in   1  level; request a program run
//  abort            in   1  level; stop, drain, return to IDLE
//  door_close       in   1  1 = door shut
//  filled           in   1  water-level-high sensor
//  drained          in   1  water-level-empty sensor
//  detergent_added  in   1  detergent dispensed acknowledge
//  door_lock        out  1  lock solenoid
//  fill_valve_on    out  1  inlet valve
//  drain_valve_on   out  1  drain pump/valve
//  motor_on         out  1  drum motor
//  soap_wash        out  1  1 in WASH
//  water_wash       out  1  1 in RINSE
//  done             out  1  program complete
//  fault            out  1  sensor timeout or door opened while locked
//  state_o          out  4  current state encoding (debug)
// BEHAVIOUR
//  - All outputs are registered Moore decodes of the state.
//  - reset: state=IDLE, counters=0, all outputs 0.
//  - State encodings:
//      IDLE=0  FILL=1  DETERGENT=2  WASH=3  DRAIN=4  RFILL=5  RINSE=6  RDRAIN=7
//      SPIN=8  DONE=9  FAULT=10  ABORT=11
//  - Output decode:
//      door_lock=1 in states 1..8, 10, 11
//      fill_valve_on in FILL and RFILL
//      drain_valve_on in DRAIN, RDRAIN, SPIN, FAULT, ABORT
//      motor_on in WASH, RINSE, SPIN
//      done in DONE; fault in FAULT
//  - Transitions:
//      IDLE->FILL when start & door_close
//      FILL->DETERGENT on filled
//      DETERGENT->WASH on detergent_added
//      WASH->DRAIN when the timer expires
//      DRAIN->RFILL on drained if rinses remain (rinse_cnt loaded with RINSES in IDLE->FILL), else ->SPIN
//      RFILL->RINSE on filled
//      RINSE->RDRAIN when the timer expires
//      RDRAIN: decrement rinse_cnt; ->RFILL if the new count is nonzero, else ->SPIN
//      SPIN->DONE when the timer expires
//      DONE->IDLE when start=0
//  - Timer: loaded with TICKS-1 on entry to a timed state; decrements every cycle; exits on
//    the cycle it reads 0. Motor is therefore high exactly TICKS cycles per timed state.
//  - Watchdog:
//      cleared on entry to FILL, RFILL, DRAIN, RDRAIN; increments each cycle in those states
//      reaching FILL_LIMIT (fill states) or DRAIN_LIMIT (drain states) before the sensor -> FAULT
//      sensor and limit reached on the same cycle: sensor wins
//  - door_close=0 in any locked state except FAULT/ABORT -> FAULT (next cycle).
//  - abort=1 in states 1..8 -> ABORT; the door-open fault has priority over abort.
//      ABORT->IDLE on drained
//  - FAULT: drain open and door locked until drained=1, then door_lock=0.
//    FAULT stays latched; exits to IDLE only when drained & ~start.
//  - start held high after DONE does not restart a run; it must drop first.
//  - Asserting reset mid-run forces IDLE immediately (valves and motor off asynchronously).
//  - filled and drained are treated as synchronous to clk; no internal synchronisers.
// TESTING
//  1. Nominal, RINSES=2: start=door_close=1, filled 3 cycles after each fill, drained 3 after
//     each drain, detergent 2 cycles after DETERGENT.
//     -> WASH motor 20 cycles, 2 RINSE windows of 10 cycles, SPIN 15 cycles,
//        done=1, door_lock=0 in DONE.
//  2. RINSES=0 -> DRAIN goes straight to SPIN; water_wash never asserted.
//  3. filled held 0 after start -> FAULT exactly at FILL_LIMIT=50 cycles in FILL,
//     fill_valve_on=0, drain_valve_on=1; door_lock drops only after drained=1.
//  4. door_close drops mid-WASH -> next cycle fault=1, motor_on=0.
//     abort mid-RINSE -> ABORT, drain on, IDLE after drained.
//  5. reset pulsed mid-SPIN -> all outputs 0 asynchronously, state_o=0.
//     start held high through DONE -> no second run until start toggles low then high.
//  6. filled and FILL_LIMIT reached on the same cycle -> DETERGENT, not FAULT.

Source files
------------

// File: rtl/wash_cycle_sequencer.sv
// Washing-machine program sequencer: fill, detergent, wash, drain, rinses, spin.
// Owns the door lock, valves and motor. A down-counter times the motor phases and a
// watchdog bounds the fill/drain phases. Outputs are registered decodes of the next
// state, so they line up cycle-for-cycle with state_o.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  IDLE      | waiting for start with the door shut
//  FILL      | inlet valve open until filled (watchdog running)
//  DETERGENT | waiting for the detergent dispenser acknowledge
//  WASH      | soap wash, motor on for WASH_TICKS cycles
//  DRAIN     | drain open until drained (watchdog running)
//  RFILL     | rinse refill until filled (watchdog running)
//  RINSE     | water wash, motor on for RINSE_TICKS cycles
//  RDRAIN    | rinse drain until drained, then count one rinse off
//  SPIN      | motor and drain on for SPIN_TICKS cycles
//  DONE      | program complete, door released, waits for start to drop
//  FAULT     | latched; drains, unlocks once dry, leaves when dry and start low
//  ABORT     | drains, returns to IDLE when dry
module wash_cycle_sequencer #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned WASH_TICKS  = 20,
    parameter int unsigned RINSE_TICKS = 10,
    parameter int unsigned SPIN_TICKS  = 15,
    parameter int unsigned RINSES      = 2,
    parameter int unsigned FILL_LIMIT  = 50,
    parameter int unsigned DRAIN_LIMIT = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       door_close,
    input  logic       filled,
    input  logic       drained,
    input  logic       detergent_added,
    output logic       door_lock,
    output logic       fill_valve_on,
    output logic       drain_valve_on,
    output logic       motor_on,
    output logic       soap_wash,
    output logic       water_wash,
    output logic       done,
    output logic       fault,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FILL      = 4'd1,
        S_DETERGENT = 4'd2,
        S_WASH      = 4'd3,
        S_DRAIN     = 4'd4,
        S_RFILL     = 4'd5,
        S_RINSE     = 4'd6,
        S_RDRAIN    = 4'd7,
        S_SPIN      = 4'd8,
        S_DONE      = 4'd9,
        S_FAULT     = 4'd10,
        S_ABORT     = 4'd11
    } state_t;

    localparam logic [CNT_W-1:0] WASH_LOAD  = CNT_W'(WASH_TICKS - 1);
    localparam logic [CNT_W-1:0] RINSE_LOAD = CNT_W'(RINSE_TICKS - 1);
    localparam logic [CNT_W-1:0] SPIN_LOAD  = CNT_W'(SPIN_TICKS - 1);
    localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_LIMIT - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_LIMIT - 1);
    localparam logic [CNT_W-1:0] RINSE_INIT = CNT_W'(RINSES);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] watchdog;
    logic [CNT_W-1:0] rinse_cnt;
    logic [CNT_W-1:0] rinse_dec;
    logic             fault_dry;
    logic             run_state;
    logic             watch_state;
    logic             door_lock_d, fill_d, drain_d, motor_d, soap_d, water_d, done_d, fault_d;

    // Locked program states: door-open faults and abort apply only here.
    assign run_state   = (state != S_IDLE) && (state != S_DONE) &&
                         (state != S_FAULT) && (state != S_ABORT);
    assign watch_state = (state == S_FILL) || (state == S_RFILL) ||
                         (state == S_DRAIN) || (state == S_RDRAIN);
    assign rinse_dec   = rinse_cnt - 1'b1;
    assign state_o     = state;

    // Next-state logic; a sensor arriving on the limit cycle wins over the watchdog.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:      if (start && door_close) next_state = S_FILL;
            S_FILL: begin
                if (filled)                      next_state = S_DETERGENT;
                else if (watchdog == FILL_LAST)  next_state = S_FAULT;
            end
            S_DETERGENT: if (detergent_added) next_state = S_WASH;
            S_WASH:      if (timer == '0) next_state = S_DRAIN;
            S_DRAIN: begin
                if (drained)                     next_state = (rinse_cnt != '0) ? S_RFILL : S_SPIN;
                else if (watchdog == DRAIN_LAST) next_state = S_FAULT;
            end
            S_RFILL: begin
                if (filled)                      next_state = S_RINSE;
                else if (watchdog == FILL_LAST)  next_state = S_FAULT;
            end
            S_RINSE:     if (timer == '0) next_state = S_RDRAIN;
            S_RDRAIN: begin
                if (drained)                     next_state = (rinse_dec != '0) ? S_RFILL : S_SPIN;
                else if (watchdog == DRAIN_LAST) next_state = S_FAULT;
            end
            S_SPIN:      if (timer == '0) next_state = S_DONE;
            S_DONE:      if (!start) next_state = S_IDLE;
            S_FAULT:     if (drained && !start) next_state = S_IDLE;
            S_ABORT:     if (drained) next_state = S_IDLE;
            default:     next_state = S_IDLE;
        endcase
        if (run_state) begin
            if (!door_close)  next_state = S_FAULT;
            else if (abort)   next_state = S_ABORT;
        end
    end

    // Output decode of the state being entered, registered alongside the state.
    always_comb begin
        door_lock_d = 1'b0;
        fill_d      = 1'b0;
        drain_d     = 1'b0;
        motor_d     = 1'b0;
        soap_d      = 1'b0;
        water_d     = 1'b0;
        done_d      = 1'b0;
        fault_d     = 1'b0;
        case (next_state)
            S_FILL, S_RFILL:  begin door_lock_d = 1'b1; fill_d = 1'b1; end
            S_DETERGENT:      door_lock_d = 1'b1;
            S_WASH:           begin door_lock_d = 1'b1; motor_d = 1'b1; soap_d = 1'b1; end
            S_DRAIN, S_RDRAIN: begin door_lock_d = 1'b1; drain_d = 1'b1; end
            S_RINSE:          begin door_lock_d = 1'b1; motor_d = 1'b1; water_d = 1'b1; end
            S_SPIN:           begin door_lock_d = 1'b1; motor_d = 1'b1; drain_d = 1'b1; end
            S_DONE:           done_d = 1'b1;
            S_ABORT:          begin door_lock_d = 1'b1; drain_d = 1'b1; end
            S_FAULT: begin
                drain_d     = 1'b1;
                fault_d     = 1'b1;
                // The door stays locked until the drum has been seen empty once.
                door_lock_d = !((state == S_FAULT) && (fault_dry || drained));
            end
            default: ;
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            door_lock      <= 1'b0;
            fill_valve_on  <= 1'b0;
            drain_valve_on <= 1'b0;
            motor_on       <= 1'b0;
            soap_wash      <= 1'b0;
            water_wash     <= 1'b0;
            done           <= 1'b0;
            fault          <= 1'b0;
        end else begin
            state          <= next_state;
            door_lock      <= door_lock_d;
            fill_valve_on  <= fill_d;
            drain_valve_on <= drain_d;
            motor_on       <= motor_d;
            soap_wash      <= soap_d;
            water_wash     <= water_d;
            done           <= done_d;
            fault          <= fault_d;
        end
    end

    // Phase timer, watchdog, rinse counter and the FAULT dry flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer     <= '0;
            watchdog  <= '0;
            rinse_cnt <= '0;
            fault_dry <= 1'b0;
        end else begin
            if (next_state != state) begin
                watchdog <= '0;
                case (next_state)
                    S_WASH:  timer <= WASH_LOAD;
                    S_RINSE: timer <= RINSE_LOAD;
                    S_SPIN:  timer <= SPIN_LOAD;
                    default: timer <= '0;
                endcase
            end else begin
                if (timer != '0) timer <= timer - 1'b1;
                if (watch_state) watchdog <= watchdog + 1'b1;
            end
            if ((state == S_IDLE) && (next_state == S_FILL))
                rinse_cnt <= RINSE_INIT;
            else if ((state == S_RDRAIN) && ((next_state == S_RFILL) || (next_state == S_SPIN)))
                rinse_cnt <= rinse_dec;
            fault_dry <= (state == S_FAULT) && (fault_dry || drained);
        end
    end

endmodule
